add_round_key: RTL and testbench



---
 rtl/add_round_key.sv | 80 ++++++++
 tb/tb_add_round_key.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/add_round_key.sv
// add_round_key: AES AddRoundKey stage, out = in ^ key over the 128-bit state.
// The XOR is its own inverse, so the same block serves encrypt and decrypt.
// Byte order is column-major (byte 0 = row 0, column 0). No byte is reordered.
// Optional output register: define ADD_ROUND_KEY_PIPELINE_EN.
//   Undefined (default): purely combinational, zero latency, clock/reset unused.
//   Defined: one-cycle latency, out holds while validIn is low, async reset.
module add_round_key (
    input  logic         clock,
    input  logic         reset,
    input  logic         validIn,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic         validOut,
    output logic [127:0] out
);

    // Bitwise key mixing; no carries, no byte permutation.
    function automatic logic [127:0] xor_key(input logic [127:0] state,
                                             input logic [127:0] round_key);
        xor_key = state ^ round_key;
    endfunction

    logic [127:0] mixed_s;

    // Mix the key only for qualified data; otherwise pass the state through.
    always_comb begin
        mixed_s = in;
        if (validIn) begin
            mixed_s = xor_key(in, key);
        end else begin
            mixed_s = in;
        end
    end

`ifdef ADD_ROUND_KEY_PIPELINE_EN

    logic [127:0] out_d;
    logic [127:0] out_q;
    logic         valid_d;
    logic         valid_q;

    // Next-state: capture a new result on valid data, otherwise hold the last one.
    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (validIn) begin
            out_d   = mixed_s;
            valid_d = 1'b1;
        end else begin
            out_d   = out_q;
            valid_d = 1'b0;
        end
    end

    // Output register; reset clears any in-flight result immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q   <= 128'h0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out      = out_q;
    assign validOut = valid_q;

`else

    // Clock and reset are only meaningful with the output register present.
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clock ^ reset;

    assign out      = mixed_s;
    assign validOut = validIn;

`endif

endmodule

// File: tb/tb_add_round_key.sv
// Self-checking bench for add_round_key; follows ADD_ROUND_KEY_PIPELINE_EN
// so the same file covers the combinational and registered builds.
module tb_add_round_key;

    logic         clock;
    logic         reset;
    logic         validIn;
    logic [127:0] in;
    logic [127:0] key;
    logic         validOut;
    logic [127:0] out;

    int checks;
    int errors;

    add_round_key dut (
        .clock    (clock),
        .reset    (reset),
        .validIn  (validIn),
        .in       (in),
        .key      (key),
        .validOut (validOut),
        .out      (out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] vin_state;
        logic [127:0] vkey;
        logic         vvalid;
        logic [127:0] exp_out;
        logic         exp_valid;
        string        name;
    } vec_t;

    localparam logic [127:0] APPB_IN  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] APPB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] APPB_OUT = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] ONES     = {128{1'b1}};

    vec_t vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply inputs and advance to the point where the result is observable.
    task automatic apply(input logic [127:0] s, input logic [127:0] k, input logic v);
        in      = s;
        key     = k;
        validIn = v;
`ifdef ADD_ROUND_KEY_PIPELINE_EN
        @(posedge clock);
        #1;
`else
        #1;
`endif
    endtask

    initial begin
        logic [127:0] pat;
        logic [127:0] exp;
        logic [127:0] bit_key;

        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        validIn = 1'b0;
        in      = 128'h0;
        key     = 128'h0;

        vecs[0] = '{APPB_IN, APPB_KEY, 1'b1, APPB_OUT, 1'b1, "appb_round0"};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h0, 1'b1,
                    128'h00112233445566778899aabbccddeeff, 1'b1, "zero_key"};
        vecs[2] = '{APPB_OUT, APPB_KEY, 1'b1, APPB_IN, 1'b1, "self_inverse"};
        vecs[3] = '{128'h0, ONES, 1'b1, ONES, 1'b1, "all_ones_key"};
`ifdef ADD_ROUND_KEY_PIPELINE_EN
        // Registered: drop of validIn holds the previous result (all ones).
        vecs[4] = '{APPB_IN, APPB_KEY, 1'b0, ONES, 1'b0, "valid_low_hold"};
`else
        // Combinational: drop of validIn passes the state through.
        vecs[4] = '{APPB_IN, APPB_KEY, 1'b0, APPB_IN, 1'b0, "valid_low_pass"};
`endif
        vecs[5] = '{128'h0123456789abcdeffedcba9876543210, 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f, 1'b1,
                    128'h0e2c4a6886a4c2e0f1d3b597795b3d1f, 1'b1, "nibble_key"};
        vecs[6] = '{128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa, 128'hffffffff00000000ffffffff00000000, 1'b1,
                    128'h55555555aaaaaaaa55555555aaaaaaaa, 1'b1, "mixed_key"};

        // Reset state.
        #12;
        check("reset_out", out, 128'h0);
        check("reset_valid", {127'h0, validOut}, 128'h0);

        @(posedge clock);
        #1;
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 7; i++) begin
            apply(vecs[i].vin_state, vecs[i].vkey, vecs[i].vvalid);
            check({vecs[i].name, "_out"}, out, vecs[i].exp_out);
            check({vecs[i].name, "_valid"}, {127'h0, validOut}, {127'h0, vecs[i].exp_valid});
        end

        // Walking single key bit over zero state: only that output bit set.
        for (int b = 0; b < 128; b++) begin
            bit_key    = 128'h0;
            bit_key[b] = 1'b1;
            apply(128'h0, bit_key, 1'b1);
            check($sformatf("walk_zero_%0d", b), out, bit_key);
        end

        // Walking single key bit over a patterned state toggles only that bit.
        pat = 128'hdeadbeef0123456789abcdefcafef00d;
        for (int b = 0; b < 128; b += 7) begin
            bit_key    = 128'h0;
            bit_key[b] = 1'b1;
            exp        = pat;
            exp[b]     = ~pat[b];
            apply(pat, bit_key, 1'b1);
            check($sformatf("walk_pat_%0d", b), out, exp);
        end

`ifdef ADD_ROUND_KEY_PIPELINE_EN
        // Valid drop: validOut low the next cycle, result held.
        apply(APPB_IN, APPB_KEY, 1'b1);
        check("pre_drop_out", out, APPB_OUT);
        apply(128'h0, ONES, 1'b0);
        check("drop_valid", {127'h0, validOut}, 128'h0);
        check("drop_hold", out, APPB_OUT);
        apply(128'h0, ONES, 1'b0);
        check("drop_hold2", out, APPB_OUT);

        // Asynchronous reset between edges while validOut is high.
        apply(APPB_IN, APPB_KEY, 1'b1);
        check("pre_reset_valid", {127'h0, validOut}, 128'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_out", out, 128'h0);
        check("async_reset_valid", {127'h0, validOut}, 128'h0);
        // Inputs ignored while reset is high.
        @(posedge clock);
        #1;
        check("reset_hold_out", out, 128'h0);
        check("reset_hold_valid", {127'h0, validOut}, 128'h0);
        reset = 1'b0;
        apply(APPB_IN, APPB_KEY, 1'b1);
        check("post_reset_out", out, APPB_OUT);
        check("post_reset_valid", {127'h0, validOut}, 128'h1);
`else
        // Reset and clock have no effect on the combinational path.
        reset = 1'b1;
        apply(APPB_IN, APPB_KEY, 1'b1);
        check("comb_reset_out", out, APPB_OUT);
        check("comb_reset_valid", {127'h0, validOut}, 128'h1);
        @(posedge clock);
        #1;
        check("comb_clock_out", out, APPB_OUT);
        reset = 1'b0;
        apply(APPB_OUT, APPB_KEY, 1'b0);
        check("comb_gate_out", out, APPB_OUT);
        check("comb_gate_valid", {127'h0, validOut}, 128'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
